// File: rtl/sec_timer_pkg.sv
// Shared definitions for the seconds timer: FSM encoding and the default
// timer clock frequency.
package sec_timer_pkg;

  // Run/pause control state.
  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_t;

  // PLL clkout: 50 MHz reference multiplied by 5.
  localparam int unsigned DEFAULT_CLK_FREQ_HZ = 250_000_000;

endpackage

// File: rtl/sec_timer_tick_prescaler.sv
// Divides clk down to one wrap strobe per second. The counter only advances
// while en is high, so a pause keeps the sub-second phase. The tick output is
// the combinational wrap strobe; the parent registers it so that tick, seconds
// and blink all change on the same edge.
module tick_prescaler
  import sec_timer_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_FREQ_HZ - 1);

  logic [CW-1:0] count;

  // A clear in the same cycle as the wrap swallows the pending tick.
  assign tick = en && !clr && (count == LAST);

  // Sub-second counter: clear wins, otherwise count 0..LAST while enabled.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/sec_timer.sv
// Seconds timer with start/stop/clear control, compare match and overflow
// flags. Counting is enabled in the cycle the FSM is about to be RUNNING, so
// the first tick lands exactly CLK_FREQ_HZ cycles after the start cycle.
module sec_timer
  import sec_timer_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ,
  parameter int unsigned SEC_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 clear,
  input  logic                 cmp_en,
  input  logic [SEC_WIDTH-1:0] cmp_value,
  input  logic                 match_ack,
  output logic                 tick,
  output logic [SEC_WIDTH-1:0] seconds,
  output logic                 running,
  output logic                 blink,
  output logic                 match,
  output logic                 overflow
);

  state_t               state;
  state_t               state_next;
  logic                 wrap;
  logic [SEC_WIDTH-1:0] sec_inc;

  assign sec_inc = seconds + 1'b1;
  assign running = (state == RUNNING);

  // Next-state logic: stop always wins over start.
  always_comb begin
    // NOTE: the default assignment first keeps this block free of latches.
    state_next = state;
    case (state)
      STOPPED: if (start && !stop) state_next = RUNNING;
      RUNNING: if (stop)           state_next = STOPPED;
      default:                     state_next = STOPPED;
    endcase
  end

  // FSM state register; clear leaves the run state untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= STOPPED;
    end else begin
      state <= state_next;
    end
  end

  tick_prescaler #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (state_next == RUNNING),
    .clr (clear),
    .tick(wrap)
  );

  // Tick pulse, seconds count, LED toggle and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick     <= 1'b0;
      seconds  <= '0;
      blink    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      tick <= wrap;
      if (clear) begin
        seconds  <= '0;
        overflow <= 1'b0;
      end else if (wrap) begin
        seconds <= sec_inc;
        blink   <= ~blink;
        if (&seconds) overflow <= 1'b1;
      end
    end
  end

  // Sticky compare match: a fresh match beats a simultaneous acknowledge,
  // and only a seconds update can set it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match <= 1'b0;
    end else if (clear) begin
      match <= 1'b0;
    end else if (wrap && cmp_en && (sec_inc == cmp_value)) begin
      match <= 1'b1;
    end else if (match_ack) begin
      match <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sec_timer.sv
// Self-checking bench for sec_timer (CLK_FREQ_HZ=10, SEC_WIDTH=4): directed
// scenarios plus randomized control traffic against a behavioural model.
module tb_sec_timer;

  localparam int F = 10;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         clear = 1'b0;
  logic         cmp_en = 1'b0;
  logic [W-1:0] cmp_value = '0;
  logic         match_ack = 1'b0;
  logic         tick;
  logic [W-1:0] seconds;
  logic         running;
  logic         blink;
  logic         match;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state.
  bit m_run, m_tick, m_blink, m_match, m_ovf;
  int m_phase, m_sec;

  // Cycle bookkeeping for directed scenarios.
  int cyc, ticks, first_tick, last_tick;

  sec_timer #(
    .CLK_FREQ_HZ(F),
    .SEC_WIDTH  (W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .cmp_en   (cmp_en),
    .cmp_value(cmp_value),
    .match_ack(match_ack),
    .tick     (tick),
    .seconds  (seconds),
    .running  (running),
    .blink    (blink),
    .match    (match),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_tick = 0; m_blink = 0; m_match = 0; m_ovf = 0;
    m_phase = 0; m_sec = 0;
  endtask

  // One clock edge of the reference behaviour, using the inputs as sampled.
  task automatic model_update();
    bit go;
    bit set;
    go     = m_run ? !stop : (start && !stop);
    set    = 0;
    m_tick = 0;
    if (clear) begin
      m_phase = 0; m_sec = 0; m_ovf = 0; m_match = 0;
    end else begin
      if (go) begin
        if (m_phase == F - 1) begin
          m_phase = 0;
          m_tick  = 1;
          m_blink = !m_blink;
          m_sec   = (m_sec + 1) % (1 << W);
          if (m_sec == 0) m_ovf = 1;
          if (cmp_en && m_sec == int'(cmp_value)) set = 1;
        end else begin
          m_phase = m_phase + 1;
        end
      end
      if (set) m_match = 1;
      else if (match_ack) m_match = 0;
    end
    m_run = go;
  endtask

  task automatic compare_all();
    check("tick",     32'(tick),     32'(m_tick));
    check("seconds",  32'(seconds),  32'(m_sec));
    check("running",  32'(running),  32'(m_run));
    check("blink",    32'(blink),    32'(m_blink));
    check("match",    32'(match),    32'(m_match));
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // Apply current inputs across one edge, check, then drop the pulses.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
    if (tick) begin
      ticks++;
      last_tick = cyc + 1;
      if (first_tick < 0) first_tick = cyc + 1;
    end
    cyc++;
    start = 0; stop = 0; clear = 0; match_ack = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must drop at once.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_tick",     32'(tick),     32'd0);
    check("rst_seconds",  32'(seconds),  32'd0);
    check("rst_running",  32'(running),  32'd0);
    check("rst_blink",    32'(blink),    32'd0);
    check("rst_match",    32'(match),    32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    cyc = 0; ticks = 0; first_tick = -1; last_tick = -1;
  endtask

  initial begin
    int restart;

    // Power-on reset and idle: nothing moves.
    do_reset();
    run(5);
    check("idle_ticks", 32'(ticks), 32'd0);

    // Basic counting: ticks at cycles 10, 20, 30.
    do_reset();
    start = 1; step();
    run(34);
    check("a_first_tick", 32'(first_tick), 32'd10);
    check("a_last_tick",  32'(last_tick),  32'd30);
    check("a_ticks",      32'(ticks),      32'd3);
    check("a_seconds",    32'(seconds),    32'd3);
    check("a_blink",      32'(blink),      32'd1);
    check("a_running",    32'(running),    32'd1);

    // Pause at cycle 5, resume: phase is kept, tick 5 cycles after restart.
    do_reset();
    start = 1; step();
    run(4);
    stop = 1; step();
    run(20);
    check("b_paused_ticks", 32'(ticks), 32'd0);
    restart = cyc;
    start = 1; step();
    run(5);
    check("b_tick_delay", 32'(first_tick - restart), 32'd5);
    check("b_seconds",    32'(seconds),              32'd1);

    // Compare match with ack coinciding with the set, then a plain ack.
    do_reset();
    cmp_en = 1; cmp_value = 4'd2;
    start = 1; step();
    run(18);
    check("c_match_before", 32'(match), 32'd0);
    match_ack = 1; step();
    check("c_match_set",   32'(match),   32'd1);
    check("c_match_secs",  32'(seconds), 32'd2);
    match_ack = 1; step();
    check("c_match_acked", 32'(match),   32'd0);
    // Moving the compare value onto the current count must not set match.
    cmp_value = 4'd2; step();
    check("c_no_retro", 32'(match), 32'd0);
    cmp_en = 0;

    // Seconds wrap 15 -> 0 on tick 16, then clear keeps running.
    do_reset();
    start = 1; step();
    run(159);
    check("d_ticks",    32'(ticks),    32'd16);
    check("d_tick",     32'(tick),     32'd1);
    check("d_seconds",  32'(seconds),  32'd0);
    check("d_overflow", 32'(overflow), 32'd1);
    clear = 1; step();
    check("d_clr_secs", 32'(seconds),  32'd0);
    check("d_clr_ovf",  32'(overflow), 32'd0);
    check("d_clr_run",  32'(running),  32'd1);

    // Start and stop together: stop wins.
    do_reset();
    start = 1; stop = 1; step();
    run(30);
    check("e_running", 32'(running), 32'd0);
    check("e_ticks",   32'(ticks),   32'd0);

    // Reset mid-run at prescaler 7: no tick afterwards until a new start.
    do_reset();
    start = 1; step();
    run(6);
    do_reset();
    run(30);
    check("f_ticks",   32'(ticks),   32'd0);
    check("f_running", 32'(running), 32'd0);

    // Randomized control traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom % 8) == 0;
      stop      = ($urandom % 24) == 0;
      clear     = ($urandom % 60) == 0;
      match_ack = ($urandom % 5) == 0;
      if (($urandom % 16) == 0) cmp_en = ~cmp_en;
      if (($urandom % 12) == 0) cmp_value = W'($urandom);
      if (($urandom % 700) == 0) do_reset();
      else step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
